hyperbus_burst_splitter: RTL
============================

Name: hyperbus_burst_splitter

Overview:
- Single-clock splitter in the system domain, between the AXI front-end and the transfer CDC.
- Breaks each linear HyperBus transfer into sub-transfers that never cross a device page boundary and never exceed a runtime maximum burst length (the tCSM budget).
- Wrapped bursts pass through unsplit.
- Parametrised in PHY count (word size), address, length and chip-select widths.

Parameters:
NumPhys, 2, parallel PHYs; word size is 2*NumPhys bytes
NumChips, 2, width of the one-hot chip-select field
AddrWidth, 32, byte-address width
LenWidth, 16, word-count field width; encoding is words minus 1
BoundaryLog, 10, page size is 2^BoundaryLog bytes; sub-transfers never cross it

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
in_addr_i  in  AddrWidth  start byte address; low log2(2*NumPhys) bits ignored (treated as 0)
in_len_i  in  LenWidth  transfer length, words minus 1
in_write_i  in  1  write transfer
in_wrap_i  in  1  wrapped burst; never split
in_cs_i  in  NumChips  one-hot chip select
in_valid_i  in  1  transfer valid
in_ready_o  out  1  transfer accepted
max_burst_i  in  LenWidth  maximum words per sub-transfer; 0 = unlimited; sampled at accept
out_addr_o  out  AddrWidth  sub-transfer byte address
out_len_o  out  LenWidth  sub-transfer length, words minus 1
out_write_o  out  1  copy of the latched write flag
out_wrap_o  out  1  copy of the latched wrap flag
out_cs_o  out  NumChips  copy of the latched chip select
out_last_o  out  1  final sub-transfer of the parent transfer
out_valid_o  out  1  sub-transfer valid
out_ready_i  in  1  sub-transfer accepted
busy_o  out  1  a transfer is being split

Behaviour:
- States: IDLE and SPLIT.
- Reset (asynchronous, any state): state=IDLE. Registered outputs go to: out_valid_o=0, busy_o=0, out_addr_o=0, out_len_o=0, out_write_o=0, out_wrap_o=0, out_cs_o=0, out_last_o=0. in_ready_o=1 once reset deasserts. Any transfer in flight is dropped and no partial sub-transfers are replayed.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&in_ready_o, latch: word-aligned addr, remaining = in_len_i+1 (internal width LenWidth+1), write, wrap, cs and max_burst_i. Go to SPLIT.
- SPLIT:
  - in_ready_o=0 (no overlap of parent transfers) and busy_o=1.
  - out_valid_o=1 starting the cycle after accept, giving a latency of 1 cycle.
  - Chunk size in words, where word = 2*NumPhys:
    - wrap=1: chunk = remaining.
    - wrap=0: chunk = min(remaining, to_boundary, max_burst if max_burst!=0).
    - to_boundary = (2^BoundaryLog - (addr mod 2^BoundaryLog)) / word.
  - out_len_o = chunk-1. out_last_o = (chunk==remaining).
  - On out_valid_o&out_ready_i:
    - addr += chunk*word, modulo 2^AddrWidth (wraps at the top of the address space).
    - remaining -= chunk.
    - If out_last_o: go to IDLE; out_valid_o=0 next cycle. Otherwise present the next chunk the next cycle.
  - Throughput: one sub-transfer per cycle while out_ready_i=1.
- Handshake rules:
  - While out_valid_o=1 and out_ready_i=0, all out_* outputs hold stable.
  - out_valid_o never drops without a handshake, except on reset.
- Config sampling: a max_burst_i change during SPLIT has no effect until the next accept.
- Maximum-length case: in_len_i = 2^LenWidth-1 is legal; remaining needs LenWidth+1 bits.
- Chunk bound: every chunk is at most min(2^LenWidth, 2^BoundaryLog/word), so out_len_o always fits in LenWidth bits.

Test Plan:
All scenarios use NumPhys=1 (word=2B) and BoundaryLog=10 (512 words per page).
- Single chunk: addr 0x000, in_len_i=99, max 0 -> one sub-transfer: addr 0x000, len 99, last=1; out_valid_o rises 1 cycle after accept.
- Boundary split: addr 0x3F0, in_len_i=19, max 0 -> (0x3F0, len 7, last=0) then (0x400, len 11, last=1).
- Max-burst split: addr 0x000, in_len_i=299, max 128 -> (0x000, 127), (0x100, 127), (0x200, 43, last=1) on consecutive cycles with out_ready_i=1.
- Backpressure: scenario 3 with out_ready_i=0 for 5 cycles on chunk 2 -> addr 0x100 and len 127 held stable; in_ready_o=0 and busy_o=1 throughout.
- Wrapped burst: addr 0x3F0, in_len_i=63, wrap=1, max 16 -> exactly one sub-transfer: 0x3F0, len 63, wrap=1, last=1.
- Reset mid-transfer: assert rst_i during chunk 2 of scenario 3 -> out_valid_o=0 immediately; in_ready_o=1 after release; no further sub-transfers. A new transfer at 0xFFFFFFFC with in_len_i=3, NumPhys=1 -> (0xFFFFFFFC, len 1) then (0x00000000, len 1, last=1).

Source files
------------

// File: rtl/hyperbus_burst_splitter.sv
// Splits linear HyperBus transfers into sub-transfers bounded by the device page
// and a runtime maximum burst length; wrapped bursts are forwarded whole.
module hyperbus_burst_splitter #(
  parameter int NumPhys     = 2,
  parameter int NumChips    = 2,
  parameter int AddrWidth   = 32,
  parameter int LenWidth    = 16,
  parameter int BoundaryLog = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] in_addr_i,
  input  logic [LenWidth-1:0]  in_len_i,
  input  logic                 in_write_i,
  input  logic                 in_wrap_i,
  input  logic [NumChips-1:0]  in_cs_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [LenWidth-1:0]  max_burst_i,
  output logic [AddrWidth-1:0] out_addr_o,
  output logic [LenWidth-1:0]  out_len_o,
  output logic                 out_write_o,
  output logic                 out_wrap_o,
  output logic [NumChips-1:0]  out_cs_o,
  output logic                 out_last_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o
);

  localparam int WordBytes   = 2 * NumPhys;
  localparam int WordLog     = $clog2(WordBytes);
  localparam int PageWordLog = BoundaryLog - WordLog;
  localparam int RemW        = LenWidth + 1;
  localparam int ChunkW      = (RemW > PageWordLog + 1) ? RemW : PageWordLog + 1;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t               state;
  logic [RemW-1:0]      rem_q;
  logic [LenWidth-1:0]  max_q;

  logic [AddrWidth-1:0] acc_addr, nxt_addr;
  logic [RemW-1:0]      acc_rem, cur_chunk, nxt_rem;
  logic [ChunkW-1:0]    acc_chunk, nxt_chunk;
  logic                 unused_addr_bits;

  // Largest chunk allowed from a given page offset (in words) and remaining count.
  function automatic logic [ChunkW-1:0] calc_chunk(
    input logic [PageWordLog-1:0] page_word,
    input logic [RemW-1:0]        rem,
    input logic                   wrap,
    input logic [LenWidth-1:0]    mx
  );
    logic [ChunkW-1:0] c;
    logic [ChunkW-1:0] to_bnd;
    c      = ChunkW'(rem);
    to_bnd = (ChunkW'(1) << PageWordLog) - ChunkW'(page_word);
    if (!wrap) begin
      if (to_bnd < c) c = to_bnd;
      if ((mx != '0) && (ChunkW'(mx) < c)) c = ChunkW'(mx);
    end
    return c;
  endfunction

  assign unused_addr_bits = ^in_addr_i[WordLog-1:0];
  assign in_ready_o       = (state == IDLE);

  always_comb begin
    acc_addr  = {in_addr_i[AddrWidth-1:WordLog], {WordLog{1'b0}}};
    acc_rem   = {1'b0, in_len_i} + RemW'(1);
    acc_chunk = calc_chunk(acc_addr[BoundaryLog-1:WordLog], acc_rem, in_wrap_i, max_burst_i);
    cur_chunk = {1'b0, out_len_o} + RemW'(1);
    nxt_addr  = out_addr_o + (AddrWidth'(cur_chunk) << WordLog);
    nxt_rem   = rem_q - cur_chunk;
    nxt_chunk = calc_chunk(nxt_addr[BoundaryLog-1:WordLog], nxt_rem, out_wrap_o, max_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rem_q       <= '0;
      max_q       <= '0;
      out_addr_o  <= '0;
      out_len_o   <= '0;
      out_write_o <= 1'b0;
      out_wrap_o  <= 1'b0;
      out_cs_o    <= '0;
      out_last_o  <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            state       <= SPLIT;
            rem_q       <= acc_rem;
            max_q       <= max_burst_i;
            out_addr_o  <= acc_addr;
            out_len_o   <= LenWidth'(acc_chunk - ChunkW'(1));
            out_last_o  <= (acc_chunk == ChunkW'(acc_rem));
            out_write_o <= in_write_i;
            out_wrap_o  <= in_wrap_i;
            out_cs_o    <= in_cs_i;
            out_valid_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        SPLIT: begin
          // out_* only move on a handshake, so they hold under backpressure.
          if (out_ready_i) begin
            if (out_last_o) begin
              state       <= IDLE;
              out_valid_o <= 1'b0;
              busy_o      <= 1'b0;
            end else begin
              rem_q      <= nxt_rem;
              out_addr_o <= nxt_addr;
              out_len_o  <= LenWidth'(nxt_chunk - ChunkW'(1));
              out_last_o <= (nxt_chunk == ChunkW'(nxt_rem));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
